uartcon_tx_arb: RTL and testbench
=================================

Name: uartcon_tx_arb

Overview:
Round-robin, packet-locking arbiter that shares one UART byte transmitter between NREQ requesters. Each requester offers bytes with a valid/ready handshake. The block forwards one byte at a time on the transmitter's valid/load/data interface and holds the grant until the requester's last byte, so packets never interleave on txd. It sits between the debug/control sources and the UART transmit engine.

Parameters:
NREQ, 4, number of requesters (1..8; non-power-of-2 allowed)
TIMEOUT_CYCLES, 1024, idle cycles tolerated inside a locked packet (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
req_valid  input  NREQ  per-requester byte valid
req_data  input  8*NREQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  input  NREQ  byte is the last of its packet
req_ready  output  NREQ  byte accepted on this edge (valid&ready)
tx_valid  output  1  byte available to the transmitter
tx_data  output  8  byte to the transmitter
tx_load  input  1  transmitter has latched tx_data (one-cycle pulse)
grant_id  output  clog2(NREQ) (min 1)  current/last granted requester
busy  output  1  state != S_IDLE
timeout_err  output  1  one-cycle pulse on lock timeout (tied 0 without the feature)

Behaviour:
- One clock; reset is synchronous and active-high. The port is named rst. All state changes happen on the rising edge of clk.
- Reset values: tx_valid=0, tx_data=0, grant_id=0, busy=0, timeout_err=0, state=S_IDLE, rr_ptr=0 (requester 0 has highest priority), lock=0. req_ready is combinational and is 0 in reset state because of S_IDLE with no valid.
- S_IDLE:
  - winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap NREQ-1 -> 0.
  - req_ready[winner]=1 combinationally. On the edge: tx_data <= byte, tx_valid <= 1, grant_id <= winner, last_q <= req_last[winner]. Go to S_LOAD.
  - If no req_valid, stay in S_IDLE.
- S_LOAD:
  - Hold tx_valid=1 with tx_data stable until tx_load=1. All req_ready=0.
  - On tx_load: tx_valid <= 0.
    - If last_q=1: rr_ptr <= grant_id+1 (wrap), go to S_IDLE.
    - Otherwise go to S_LOCK.
- S_LOCK:
  - Only requester grant_id is considered; other requesters are ignored even if valid.
  - req_ready[grant_id] = req_valid[grant_id]. On acceptance, capture the byte as in S_IDLE and go to S_LOAD.
- Latency: byte accepted at edge N -> tx_valid=1 from N+1. The transmitter latches it on its next idle cycle.
- tx_load outside S_LOAD is ignored.
- Back-to-back packets: rr_ptr advances only after a last byte, so fairness is per packet.
- At most one req_ready bit is high in any cycle. req_ready depends combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Reset mid-operation: the next edge returns to reset values and any in-flight byte is dropped. The transmitter reset is driven from the same source (rst_n = ~rst).

Optional Feature:
UARTCON_TX_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to S_LOCK and increments each S_LOCK cycle with req_valid[grant_id]=0.
  - When it reaches TIMEOUT_CYCLES: timeout_err=1 for one cycle, lock released, rr_ptr <= grant_id+1, go to S_IDLE.
  - A byte accepted in the same cycle as the terminal count wins; no timeout is raised.
- Undefined: no counter; S_LOCK waits indefinitely; timeout_err tied 0.

Decomposition:
- Shared package uartcon_pkg: state encodings S_IDLE/S_LOAD/S_LOCK, UART_BYTE_W=8.
- One natural sub-module: uartcon_rr_pick, a combinational round-robin selector (req vector, rr_ptr -> winner index, any_valid).

Test Plan:
1. Single byte: req0 sends 0x55, last=1, with a behavioural transmitter model -> req_ready[0] pulses once; tx_valid=1 the next cycle with tx_data=0x55; tx_valid drops the cycle after tx_load; busy=0 after; txd shows 0x55 framed.
2. Contention: req0-3 all valid with single-byte packets 0xA0-0xA3 from reset -> transmit order A0,A1,A2,A3. A second round is again requester 0 first, because rr_ptr has wrapped.
3. Packet lock: req0 sends 0x11,0x22,0x33 (last on 0x33) while req1 holds 0x44 valid -> order 11,22,33,44 with no req_ready[1] before 0x33 is loaded.
4. Stall: hold tx_load=0 for 50 cycles in S_LOAD -> tx_valid=1 and tx_data stable throughout; no req_ready pulses; busy=1.
5. Timeout (macro on, TIMEOUT_CYCLES=16): req2 sends 0x7E last=0, then drops valid while req3 is valid -> timeout_err pulses 16 S_LOCK cycles later and req3 is granted next. With the macro off, req3 is never granted.
6. Reset in S_LOAD: assert rst for one cycle -> next edge tx_valid=0, busy=0, grant_id=0. A subsequent req1 request is granted normally.

Source files
------------

// File: rtl/uartcon_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, byte width
// and the round-robin successor helper.
package uartcon_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_LOCK = 2'd2
  } arb_state_e;

  // Next index after idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    if (idx >= n - 1) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/uartcon_rr_pick.sv
// Combinational round-robin selector: first set bit of req searching upward
// from ptr with wrap at NREQ-1.
module uartcon_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_valid
);

  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

  logic [IDW:0]   sum_s;
  logic [IDW-1:0] idx_s;

  // Scan from the farthest offset down so the nearest valid offset is written last
  always_comb begin
    winner    = '0;
    sum_s     = '0;
    idx_s     = '0;
    any_valid = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum_s  = {1'b0, ptr} + (IDW + 1)'(k);
      sum_s  = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
      idx_s  = sum_s[IDW-1:0];
      winner = req[idx_s] ? idx_s : winner;
    end
  end

endmodule

// File: rtl/uartcon_tx_arb.sv
// Round-robin, packet-locking arbiter in front of a UART byte transmitter.
// Optional lock timeout enabled by defining UARTCON_TX_ARB_TIMEOUT_EN.
module uartcon_tx_arb
  import uartcon_pkg::*;
#(
  parameter int  NREQ           = 4,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int IDW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]             req_last,
  output logic [NREQ-1:0]             req_ready,
  output logic                        tx_valid,
  output logic [UART_BYTE_W-1:0]      tx_data,
  input  logic                        tx_load,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  arb_state_e             state_q, state_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                   last_q, last_d;
  logic                   busy_q;
  logic                   timeout_err_q, timeout_err_d;

  logic [IDW-1:0]         pick_id_s, sel_id_s;
  logic                   pick_any_s, accept_s, sel_last_s, tmo_hit_s;
  logic [NREQ-1:0]        ready_s;
  logic [UART_BYTE_W-1:0] sel_byte_s;

  uartcon_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .winner    (pick_id_s),
    .any_valid (pick_any_s)
  );

  // Decide which requester may hand over a byte this cycle and mux its data
  always_comb begin
    ready_s    = '0;
    sel_id_s   = grant_id_q;
    sel_byte_s = '0;
    sel_last_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        sel_id_s           = pick_id_s;
        ready_s[pick_id_s] = pick_any_s;
      end
      S_LOCK:  ready_s[grant_id_q] = req_valid[grant_id_q];
      default: ready_s = '0;
    endcase
    for (int i = 0; i < NREQ; i++) begin
      sel_byte_s = (sel_id_s == IDW'(i)) ? req_data[i*UART_BYTE_W +: UART_BYTE_W] : sel_byte_s;
      sel_last_s = (sel_id_s == IDW'(i)) ? req_last[i] : sel_last_s;
    end
  end

  assign accept_s = |ready_s;

`ifdef UARTCON_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // A waiting byte always beats the terminal count
  assign tmo_hit_s = (state_q == S_LOCK) && !accept_s &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count idle cycles spent inside a locked packet
  always_comb begin
    if ((state_q == S_LOCK) && !accept_s) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Lock idle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Arbitration FSM next state
  always_comb begin
    state_d       = state_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    last_d        = last_q;
    rr_ptr_d      = rr_ptr_q;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE, S_LOCK: begin
        if (accept_s) begin
          tx_data_d  = sel_byte_s;
          tx_valid_d = 1'b1;
          grant_id_d = sel_id_s;
          last_d     = sel_last_s;
          state_d    = S_LOAD;
        end else if (tmo_hit_s) begin
          timeout_err_d = 1'b1;
          rr_ptr_d      = IDW'(rr_next(int'(grant_id_q), NREQ));
          state_d       = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (tx_load) begin
          tx_valid_d = 1'b0;
          if (last_q) begin
            rr_ptr_d = IDW'(rr_next(int'(grant_id_q), NREQ));
            state_d  = S_IDLE;
          end else begin
            state_d = S_LOCK;
          end
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      last_q        <= 1'b0;
      rr_ptr_q      <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      last_q        <= last_d;
      rr_ptr_q      <= rr_ptr_d;
      busy_q        <= (state_d != S_IDLE);
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready   = ready_s;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uartcon_tx_arb.sv
// Bench for uartcon_tx_arb: requester queues feed the DUT, a scoreboard of
// {grant_id, byte} is checked at every transmitter load.
module tb_uartcon_tx_arb;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NREQ-1:0] req_valid, req_last, req_ready;
  logic [8*NREQ-1:0] req_data;
  logic            tx_valid, tx_load, busy, timeout_err;
  logic [7:0]      tx_data;
  logic [1:0]      grant_id;

  uartcon_tx_arb #(.NREQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic        do_rst;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [47:0] exp;    // entries {id[3:0], byte[7:0]} in expected load order
    int          n_exp;
  } vec_t;

  vec_t        vecs[6];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [8:0]  rq[NREQ][$];   // per requester {last, byte}
  logic [11:0] sb[$];
  logic        tx_hold = 1'b0;
  logic        tmo_allowed = 1'b0;
  logic        load_ev_r = 1'b0;
  logic [NREQ-1:0] last_rdy;
  int          tx_gap = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: observe handshakes on the falling edge, check and drive after the rising edge
  task automatic cyc();
    logic [NREQ-1:0] acc;
    logic [7:0]      acc_b;
    logic            ld;
    logic [11:0]     e;
    @(negedge clk);
    last_rdy = req_ready;
    chk("ready_onehot", {31'd0, ($onehot0(req_ready) && ((req_ready & ~req_valid) == '0))}, 32'd1);
    acc   = req_valid & req_ready;
    acc_b = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        acc_b = rq[i][0][7:0];
        void'(rq[i].pop_front());
      end
    end
    ld = tx_load & tx_valid;
    if (ld) begin
      if (sb.size() == 0) begin
        chk("sb_extra_load", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("load_tx_data", tx_data, e[7:0]);
        chk("load_grant_id", grant_id, e[11:8]);
      end
    end
    @(posedge clk);
    #1;
    if (acc != '0) begin
      chk("acc_tx_valid", tx_valid, 32'd1);
      chk("acc_tx_data", tx_data, acc_b);
      chk("acc_busy", busy, 32'd1);
    end
    if (ld) chk("load_drop_valid", tx_valid, 32'd0);
    if (!tmo_allowed) chk("timeout_quiet", timeout_err, 32'd0);
    load_ev_r = ld;
    if (ld) tx_gap = 3;
    else if (tx_gap > 0) tx_gap--;
    tx_load = !tx_hold && (tx_valid ? (tx_gap == 0) : ($urandom_range(0, 3) == 0));
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    sb.delete();
    drive();
    tx_load   = 1'b0;
    tx_gap    = 0;
    load_ev_r = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tx_valid", tx_valid, 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_grant_id", grant_id, 32'd0);
    chk("rst_timeout_err", timeout_err, 32'd0);
    chk("rst_req_ready", req_ready, 32'd0);
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk(nm, sb.size(), 32'd0);
  endtask

  initial begin
    int n;
    int k;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_load = 1'b0;

    vecs[0] = '{1'b1, 4'b0001, 32'h0000_0055, 48'h000_000_000_055, 1};
    vecs[1] = '{1'b1, 4'b1111, 32'hA3A2_A1A0, 48'h3A3_2A2_1A1_0A0, 4};
    vecs[2] = '{1'b0, 4'b1111, 32'hB3B2_B1B0, 48'h3B3_2B2_1B1_0B0, 4};
    vecs[3] = '{1'b0, 4'b0110, 32'h00C2_C100, 48'h000_000_2C2_1C1, 2};
    vecs[4] = '{1'b0, 4'b1001, 32'hD300_00D0, 48'h000_000_0D0_3D3, 2};
    vecs[5] = '{1'b0, 4'b0101, 32'h00E2_00E0, 48'h000_000_0E0_2E2, 2};

    do_reset();

    // Single-byte packets, contention and round-robin order
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_rst) do_reset();
      for (int i = 0; i < NREQ; i++) begin
        if (vecs[v].mask[i]) rq[i].push_back({1'b1, vecs[v].data[8*i +: 8]});
      end
      for (int j = 0; j < vecs[v].n_exp; j++) sb.push_back(vecs[v].exp[12*j +: 12]);
      drive();
      drain("vec_drain", 200);
      chk("vec_idle_busy", busy, 32'd0);
    end

    // Packet lock: req1 must wait for the whole req0 packet
    do_reset();
    rq[0].push_back({1'b0, 8'h11});
    rq[0].push_back({1'b0, 8'h22});
    rq[0].push_back({1'b1, 8'h33});
    rq[1].push_back({1'b1, 8'h44});
    sb.push_back(12'h011); sb.push_back(12'h022); sb.push_back(12'h033); sb.push_back(12'h144);
    drive();
    drain("lock_drain", 200);

    // Transmitter stall for 50 cycles in S_LOAD
    do_reset();
    tx_hold = 1'b1;
    rq[1].push_back({1'b1, 8'h5A});
    rq[2].push_back({1'b1, 8'h6B});
    sb.push_back(12'h15A); sb.push_back(12'h26B);
    drive();
    n = 0;
    while (!tx_valid && n < 10) begin
      cyc();
      n++;
    end
    chk("stall_start", tx_valid, 32'd1);
    repeat (50) begin
      cyc();
      chk("stall_tx_valid", tx_valid, 32'd1);
      chk("stall_tx_data", tx_data, 32'h5A);
      chk("stall_busy", busy, 32'd1);
      chk("stall_no_ready", last_rdy, 32'd0);
    end
    tx_hold = 1'b0;
    drain("stall_drain", 200);

    // Requester goes quiet inside a locked packet
    do_reset();
    rq[2].push_back({1'b0, 8'h7E});
    rq[3].push_back({1'b1, 8'h99});
    sb.push_back(12'h27E);
    drive();
    n = 0;
    load_ev_r = 1'b0;
    while (!load_ev_r && n < 50) begin
      cyc();
      n++;
    end
    chk("lock_first_load", load_ev_r, 32'd1);
`ifdef UARTCON_TX_ARB_TIMEOUT_EN
    tmo_allowed = 1'b1;
    k = 1;
    while (timeout_err !== 1'b1 && k < 100) begin
      cyc();
      k++;
    end
    chk("tmo_cycle", k, 32'd17);
    cyc();
    chk("tmo_pulse_width", timeout_err, 32'd0);
    tmo_allowed = 1'b0;
    sb.push_back(12'h399);
    drain("tmo_drain", 200);
`else
    k = 0;
    repeat (60) cyc();
    chk("lock_req3_waiting", rq[3].size(), 32'd1);
    chk("lock_grant_held", grant_id, 32'd2);
    chk("lock_busy", busy, 32'd1);
    rq[2].push_back({1'b1, 8'h7F});
    sb.push_back(12'h27F); sb.push_back(12'h399);
    drive();
    drain("lock_release_drain", 200);
`endif

    // Reset while a byte waits in S_LOAD, then a normal request
    do_reset();
    tx_hold = 1'b1;
    rq[2].push_back({1'b1, 8'h3C});
    sb.push_back(12'h23C);
    drive();
    repeat (3) cyc();
    chk("pre_reset_loaded", tx_valid, 32'd1);
    do_reset();
    tx_hold = 1'b0;
    rq[1].push_back({1'b1, 8'h81});
    sb.push_back(12'h181);
    drive();
    drain("post_reset_drain", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
